// File: rtl/fixed_integrate_dump_pkg.sv
// Shared fixed-point helpers: sign representation, width extension and
// saturation limits used by the integrate-and-dump datapath.
package fixed_integrate_dump_pkg;

  typedef enum logic {REP_SIGNED, REP_UNSIGNED} signrep_t;

  localparam int MAXW = 64;

  typedef struct packed {
    logic [MAXW-1:0] max;
    logic [MAXW-1:0] min;
  } sat_limits_t;

  // Extends the low w bits of x to MAXW bits; callers keep w below MAXW.
  function automatic logic [MAXW-1:0] ext(input logic [MAXW-1:0] x, input int w,
                                          input signrep_t rep);
    logic [MAXW-1:0] mask;
    logic            sign;
    mask = (64'(1) << w) - 1;
    sign = |(x & (64'(1) << (w - 1)));
    return (x & mask) | (((rep == REP_SIGNED) && sign) ? ~mask : '0);
  endfunction

  function automatic sat_limits_t sat_limits(input int w, input signrep_t rep);
    sat_limits_t lim;
    if (rep == REP_SIGNED) begin
      lim.max = (64'(1) << (w - 1)) - 1;
      lim.min = ~lim.max;
    end else begin
      lim.max = (64'(1) << w) - 1;
      lim.min = '0;
    end
    return lim;
  endfunction

endpackage

// File: rtl/fixed_integrate_dump_if.sv
// Sample-in / sum-out bus of the integrate-and-dump stage.
interface fixed_integrate_dump_if #(
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 18
);

  logic              i_valid;
  logic              i_sync;
  logic [IWIDTH-1:0] i_data;
  logic              o_valid;
  logic [OWIDTH-1:0] o_data;
  logic              o_ovfl;

  modport master (output i_valid, i_sync, i_data, input o_valid, o_data, o_ovfl);
  modport slave  (input i_valid, i_sync, i_data, output o_valid, o_data, o_ovfl);

endinterface

// File: rtl/fixed_integrate_dump_saturator.sv
// Combinational clamp of a wide value into OWIDTH bits, flagging when it clamps.
module fixed_saturator
  import fixed_integrate_dump_pkg::*;
#(
  parameter int    IWIDTH  = 18,
  parameter int    OWIDTH  = 18,
  parameter string SIGNREP = "SIGNED"
) (
  input  logic [IWIDTH-1:0] value,
  output logic [OWIDTH-1:0] result,
  output logic              ovfl
);

  localparam signrep_t    REP = (SIGNREP == "UNSIGNED") ? REP_UNSIGNED : REP_SIGNED;
  localparam sat_limits_t LIM = sat_limits(OWIDTH, REP);

  logic [MAXW-1:0] wide;
  logic            over;
  logic            under;

  // Comparing at full width keeps one code path whether or not OWIDTH can clip.
  always_comb begin
    wide  = ext(MAXW'(value), IWIDTH, REP);
    over  = 1'b0;
    under = 1'b0;
    if (REP == REP_SIGNED) begin
      over  = $signed(wide) > $signed(LIM.max);
      under = $signed(wide) < $signed(LIM.min);
    end else begin
      over  = wide > LIM.max;
    end
    if (over)       result = LIM.max[OWIDTH-1:0];
    else if (under) result = LIM.min[OWIDTH-1:0];
    else            result = wide[OWIDTH-1:0];
    ovfl = over | under;
  end

endmodule

// File: rtl/fixed_integrate_dump.sv
// Integrate-and-dump decimator: sums LENGTH accepted samples per frame and
// emits one registered, optionally saturated sum per frame.
module fixed_integrate_dump
  import fixed_integrate_dump_pkg::*;
#(
  parameter int    IWIDTH  = 16,
  parameter int    LENGTH  = 4,
  parameter int    OWIDTH  = 18,
  parameter string SIGNREP = "SIGNED"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkena,
  fixed_integrate_dump_if.slave bus
);

  localparam int          GWIDTH = IWIDTH + $clog2(LENGTH);
  localparam int          CWIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam signrep_t    REP    = (SIGNREP == "UNSIGNED") ? REP_UNSIGNED : REP_SIGNED;
  localparam logic [CWIDTH-1:0] LAST = CWIDTH'(LENGTH - 1);

  logic [GWIDTH-1:0] acc;
  logic [GWIDTH-1:0] sample;
  logic [GWIDTH-1:0] sum;
  logic [CWIDTH-1:0] cnt;
  logic              last;
  logic [OWIDTH-1:0] sat_data;
  logic              sat_ovfl;

  // A sync sample restarts the frame, so it also starts the sum from zero.
  always_comb begin
    sample = GWIDTH'(ext(MAXW'(bus.i_data), IWIDTH, REP));
    sum    = (bus.i_sync ? '0 : acc) + sample;
    last   = bus.i_sync ? (LENGTH == 1) : (cnt == LAST);
  end

  fixed_saturator #(
    .IWIDTH (GWIDTH),
    .OWIDTH (OWIDTH),
    .SIGNREP(SIGNREP)
  ) u_sat (
    .value (sum),
    .result(sat_data),
    .ovfl  (sat_ovfl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_ovfl  <= 1'b0;
    end else if (clkena) begin
      bus.o_valid <= 1'b0;
      if (bus.i_valid) begin
        if (last) begin
          acc         <= '0;
          cnt         <= '0;
          bus.o_valid <= 1'b1;
          bus.o_data  <= sat_data;
          bus.o_ovfl  <= sat_ovfl;
        end else if (bus.i_sync) begin
          acc <= sample;
          cnt <= CWIDTH'(1);
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
